video_timing_gen: RTL

Runtime-reconfigurable video timing generator for the DVI output path. Holds a table of four standard modes and switches between them only at a frame boundary, through a valid/ready request. It produces early coordinates for the pixel source, plus sync, DE and frame/line strobes. Those strobes are delayed by a configurable lead so they line up with a pipelined pixel source. It runs in the pixel-clock domain, ahead of the TMDS encoder.

---
 rtl/video_timing_pkg.sv | 43 ++++
 rtl/video_delay_line.sv | 36 +++
 rtl/video_timing_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Mode table and timing helpers shared by the video timing generator.
// Each mode record holds resolution, porches, sync widths and sync polarity.
package video_timing_pkg;

  localparam int MODE_W = 2;
  localparam int DL_W   = 6;

  typedef struct packed {
    logic [11:0] h_res;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_res;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        pol;
  } mode_t;

  function automatic mode_t mode_lookup(input logic [MODE_W-1:0] idx);
    mode_t m;
    case (idx)
      2'd1: m = '{h_res: 12'd800,  h_fp: 12'd40,  h_sync: 12'd128, h_bp: 12'd88,
                  v_res: 12'd600,  v_fp: 12'd1,   v_sync: 12'd4,   v_bp: 12'd23, pol: 1'b1};
      2'd2: m = '{h_res: 12'd1280, h_fp: 12'd110, h_sync: 12'd40,  h_bp: 12'd220,
                  v_res: 12'd720,  v_fp: 12'd5,   v_sync: 12'd5,   v_bp: 12'd20, pol: 1'b1};
      2'd3: m = '{h_res: 12'd1920, h_fp: 12'd88,  h_sync: 12'd44,  h_bp: 12'd148,
                  v_res: 12'd1080, v_fp: 12'd4,   v_sync: 12'd5,   v_bp: 12'd36, pol: 1'b1};
      default: m = '{h_res: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
                     v_res: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33, pol: 1'b0};
    endcase
    return m;
  endfunction

  function automatic int h_sta(input mode_t m);
    return -(int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp));
  endfunction

  function automatic int v_sta(input mode_t m);
    return -(int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp));
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register that retimes the strobe bundle behind the early coordinates.
// DEPTH of zero is a straight pass-through.
module video_delay_line
  import video_timing_pkg::*;
#(
  parameter int                 WIDTH   = DL_W,
  parameter int                 DEPTH   = 2,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift chain; every stage resets to the idle bundle value
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reconfigurable video timing generator: early signed coordinates plus
// lead-delayed sync/DE/line/frame strobes, with mode changes taken at frame end.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int DEFAULT_MODE = 0,
  parameter int LEAD         = 2,
  parameter int CW           = 16
) (
  input  logic                 i_pix_clk,
  input  logic                 i_rst_n,
  input  logic [1:0]           i_mode_req,
  input  logic                 i_mode_valid,
  output logic                 o_mode_ready,
  output logic                 o_mode_ack,
  output logic [1:0]           o_mode,
  output logic signed [CW-1:0] o_sx,
  output logic signed [CW-1:0] o_sy,
  output logic                 o_hs,
  output logic                 o_vs,
  output logic                 o_de,
  output logic                 o_line,
  output logic                 o_frame
);

  localparam logic [1:0]           DEF_IDX  = 2'(DEFAULT_MODE);
  localparam mode_t                DEF_M    = mode_lookup(DEF_IDX);
  localparam logic signed [CW-1:0] DEF_HSTA = CW'(h_sta(DEF_M));
  localparam logic signed [CW-1:0] DEF_VSTA = CW'(v_sta(DEF_M));
  localparam logic signed [CW-1:0] C_ONE    = {{(CW-1){1'b0}}, 1'b1};
  // Idle bundle: syncs at the default mode's inactive level, strobes low
  localparam logic [DL_W-1:0]      DL_RST   = {~DEF_M.pol, ~DEF_M.pol, 4'b0000};

  logic signed [CW-1:0] r_sx;
  logic signed [CW-1:0] r_sy;
  logic [1:0]           r_mode;
  logic [1:0]           r_pend_mode;
  logic                 r_pend;
  logic                 r_ack;

  mode_t                w_m;
  mode_t                w_next_m;
  logic [1:0]           w_next_idx;
  logic signed [31:0]   w_sx_i;
  logic signed [31:0]   w_sy_i;
  logic signed [31:0]   w_h_sta;
  logic signed [31:0]   w_v_sta;
  logic                 w_h_wrap;
  logic                 w_v_last;
  logic                 w_frame_end;
  logic                 w_accept;
  logic                 w_hs_raw;
  logic                 w_vs_raw;
  logic                 w_hs;
  logic                 w_vs;
  logic                 w_de;
  logic                 w_line;
  logic                 w_frame;
  logic [DL_W-1:0]      w_early;
  logic [DL_W-1:0]      w_late;

  assign w_m        = mode_lookup(r_mode);
  assign w_next_idx = r_pend ? r_pend_mode : r_mode;
  assign w_next_m   = mode_lookup(w_next_idx);
  assign w_accept   = i_mode_valid && !r_pend;

  // Early timing decode from the live counters and current mode
  always_comb begin
    w_sx_i      = 32'(r_sx);
    w_sy_i      = 32'(r_sy);
    w_h_sta     = h_sta(w_m);
    w_v_sta     = v_sta(w_m);
    w_h_wrap    = (w_sx_i == int'(w_m.h_res) - 32'sd1);
    w_v_last    = (w_sy_i == int'(w_m.v_res) - 32'sd1);
    w_frame_end = w_h_wrap && w_v_last;
    w_hs_raw    = (w_sx_i >= -(int'(w_m.h_sync) + int'(w_m.h_bp))) &&
                  (w_sx_i <= -int'(w_m.h_bp) - 32'sd1);
    w_vs_raw    = (w_sy_i >= -(int'(w_m.v_sync) + int'(w_m.v_bp))) &&
                  (w_sy_i <= -int'(w_m.v_bp) - 32'sd1);
    w_hs        = ~(w_hs_raw ^ w_m.pol);
    w_vs        = ~(w_vs_raw ^ w_m.pol);
    w_de        = (w_sx_i >= 32'sd0) && (w_sy_i >= 32'sd0);
    w_line      = (w_sx_i == w_h_sta);
    w_frame     = w_line && (w_sy_i == w_v_sta);
  end

  // Raster counters; the pending mode is loaded only at the last pixel of a frame
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sx   <= DEF_HSTA;
      r_sy   <= DEF_VSTA;
      r_mode <= DEF_IDX;
      r_ack  <= 1'b0;
    end else if (w_frame_end) begin
      r_sx   <= CW'(h_sta(w_next_m));
      r_sy   <= CW'(v_sta(w_next_m));
      r_mode <= w_next_idx;
      r_ack  <= r_pend;
    end else if (w_h_wrap) begin
      r_sx   <= CW'(w_h_sta);
      r_sy   <= r_sy + C_ONE;
      r_ack  <= 1'b0;
    end else begin
      r_sx   <= r_sx + C_ONE;
      r_ack  <= 1'b0;
    end
  end

  // Request holding register; a request taken on the wrap cycle waits a full frame
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend      <= 1'b0;
      r_pend_mode <= DEF_IDX;
    end else if (w_frame_end && r_pend) begin
      r_pend      <= 1'b0;
    end else if (w_accept) begin
      r_pend      <= 1'b1;
      r_pend_mode <= i_mode_req;
    end else begin
      r_pend      <= r_pend;
    end
  end

  assign w_early = {w_hs, w_vs, w_de, w_line, w_frame, r_ack};

  video_delay_line #(
    .WIDTH   (DL_W),
    .DEPTH   (LEAD),
    .RST_VAL (DL_RST)
  ) u_delay (
    .i_clk   (i_pix_clk),
    .i_rst_n (i_rst_n),
    .i_d     (w_early),
    .o_q     (w_late)
  );

  assign {o_hs, o_vs, o_de, o_line, o_frame, o_mode_ack} = w_late;
  assign o_sx         = r_sx;
  assign o_sy         = r_sy;
  assign o_mode       = r_mode;
  assign o_mode_ready = ~r_pend;

endmodule
